// File: rtl/univ_shift_register_if.sv
// Operation/handshake bundle for the universal shift register.
// Signal names follow the block's published port list.
interface univ_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [2:0]       sel;
    logic [WIDTH-1:0] in;
    logic             leftshift_in;
    logic             rightshift_in;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output sel, in, leftshift_in, rightshift_in, start, amount,
        input  out, busy, done
    );

    modport slave (
        input  sel, in, leftshift_in, rightshift_in, start, amount,
        output out, busy, done
    );
endinterface

// File: rtl/univ_shift_register.sv
// Universal shift register: single-step ops every edge in IDLE, or a latched
// op repeated 'amount' times via a small IDLE/RUN/DONE sequencer.
module univ_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 async_reset_n,
    univ_shift_register_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_din;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;

    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] d,
        input logic             li,
        input logic             ri
    );
        case (op)
            3'b000:  return v;
            3'b001:  return {v[WIDTH-2:0], li};
            3'b010:  return {ri, v[WIDTH-1:1]};
            3'b011:  return d;
            3'b100:  return {v[WIDTH-2:0], v[WIDTH-1]};
            3'b101:  return {v[0], v[WIDTH-1:1]};
            3'b110:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return '0;
        endcase
    endfunction

    // Load data is captured with the op so a repeated 011 in RUN stays stable
    // even though 'in' is ignored once the run has started.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_din   <= '0;
            r_op    <= 3'b000;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.sel;
                        r_din <= bus.in;
                        r_rem <= bus.amount;
                        if (bus.amount == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_out <= f_step(bus.sel, r_out, bus.in,
                                        bus.leftshift_in, bus.rightshift_in);
                    end
                end
                RUN: begin
                    r_out <= f_step(r_op, r_out, r_din,
                                    bus.leftshift_in, bus.rightshift_in);
                    r_rem <= r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed + randomized checks of univ_shift_register against an arithmetic
// reference model of each operation.
module tb_univ_shift_register;
    localparam int W = 8;
    localparam int C = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [W-1:0] m;

    univ_shift_register_if #(.WIDTH(W), .CNT_W(C)) bus ();

    univ_shift_register #(.WIDTH(W), .CNT_W(C)) dut (
        .clk          (clk),
        .async_reset_n(rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operation semantics expressed as plain integer arithmetic on the value.
    function automatic logic [W-1:0] mstep(int op, int v, int d, int l, int r);
        int res;
        case (op)
            0:       res = v;
            1:       res = (v * 2 + l) % 256;
            2:       res = v / 2 + r * 128;
            3:       res = d;
            4:       res = (v * 2) % 256 + v / 128;
            5:       res = v / 2 + (v % 2) * 128;
            6:       res = v / 2 + ((v >= 128) ? 128 : 0);
            default: res = 0;
        endcase
        return 8'(res);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int op, input logic [W-1:0] d, input bit l, input bit r);
        bus.sel = 3'(op); bus.in = d; bus.leftshift_in = l; bus.rightshift_in = r;
        bus.start = 1'b0;
        tick();
        m = mstep(op, m, d, l, r);
        chk("single_out", bus.out, m);
        chk("single_busy", bus.busy, 0);
        chk("single_done", bus.done, 0);
    endtask

    // Start held high through RUN with junk on the ignored inputs; dropped
    // before the DONE->IDLE edge so no second run is launched.
    task automatic run_multi(input int op, input int amt, input logic [W-1:0] d);
        bit l, r;
        bus.sel = 3'(op); bus.in = d; bus.amount = C'(amt); bus.start = 1'b1;
        tick();
        chk("k_out", bus.out, m);
        chk("k_busy", bus.busy, (amt > 0) ? 1 : 0);
        chk("k_done", bus.done, (amt == 0) ? 1 : 0);
        for (int i = 1; i <= amt; i++) begin
            bus.sel = 3'($urandom); bus.in = W'($urandom); bus.amount = C'($urandom);
            l = 1'($urandom); r = 1'($urandom);
            bus.leftshift_in = l; bus.rightshift_in = r;
            tick();
            m = mstep(op, m, d, l, r);
            chk("run_out", bus.out, m);
            chk("run_busy", bus.busy, (i < amt) ? 1 : 0);
            chk("run_done", bus.done, (i == amt) ? 1 : 0);
        end
        bus.start = 1'b0; bus.sel = 3'b000;
        tick();
        chk("post_out", bus.out, m);
        chk("post_busy", bus.busy, 0);
        chk("post_done", bus.done, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m = '0;
        rst_n = 1'b0;
        bus.sel = 3'b000; bus.in = '0; bus.leftshift_in = 1'b0;
        bus.rightshift_in = 1'b0; bus.start = 1'b0; bus.amount = '0;
        #12;
        chk("rst_out", bus.out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;

        // Single-step load then shift left
        single(3, 8'hA5, 0, 0);
        chk("load_A5", bus.out, 8'hA5);
        single(1, 8'h00, 1, 0);
        chk("shl_4B", bus.out, 8'h4B);

        // Multi-step rotate right of 81 by 3
        single(3, 8'h81, 0, 0);
        run_multi(5, 3, 8'h00);
        chk("rotr3_30", bus.out, 8'h30);

        // Arithmetic shift right by 2, then saturating by 12
        single(3, 8'h90, 0, 0);
        run_multi(6, 2, 8'h00);
        chk("asr2_E4", bus.out, 8'hE4);
        single(3, 8'h90, 0, 0);
        run_multi(6, 12, 8'h00);
        chk("asr12_FF", bus.out, 8'hFF);

        // amount=0: done next cycle, value unchanged
        run_multi(1, 0, 8'h00);
        chk("amt0_FF", bus.out, 8'hFF);

        // Rotate left wraps modulo width
        single(3, 8'h01, 0, 0);
        run_multi(4, 9, 8'h00);
        chk("rotl9_02", bus.out, 8'h02);

        // Repeated load in RUN keeps latched data
        run_multi(3, 4, 8'h3C);
        chk("load_rep", bus.out, 8'h3C);

        // Back-to-back: start held through DONE is re-accepted in IDLE
        bus.sel = 3'd4; bus.amount = 4'd1; bus.start = 1'b1;
        tick(); chk("b2b_busy1", bus.busy, 1);
        tick(); m = mstep(4, m, 0, 0, 0);
        chk("b2b_out1", bus.out, m); chk("b2b_done1", bus.done, 1);
        tick(); chk("b2b_idle_done", bus.done, 0); chk("b2b_idle_busy", bus.busy, 0);
        tick(); chk("b2b_busy2", bus.busy, 1); chk("b2b_hold", bus.out, m);
        bus.start = 1'b0;
        tick(); m = mstep(4, m, 0, 0, 0);
        chk("b2b_out2", bus.out, m); chk("b2b_done2", bus.done, 1);
        tick(); chk("b2b_end", bus.done, 0);

        // Reset between edges after two steps of a 5-step rotate
        single(3, 8'hB7, 0, 0);
        bus.sel = 3'd5; bus.amount = 4'd5; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(); tick();
        m = mstep(5, mstep(5, m, 0, 0, 0), 0, 0, 0);
        chk("mid_out", bus.out, m);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", bus.out, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        #10 rst_n = 1'b1;
        m = '0;
        bus.sel = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("nodone", bus.done, 0);
            chk("nobusy", bus.busy, 0);
        end
        single(3, 8'h5A, 0, 0);

        // Randomized mix of single steps and multi-step runs
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_multi(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), W'($urandom));
            else
                single(int'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
